mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage sequencer between execute and the byte-wide data memory. Accepts one
//  LW/LW.POI/SW/PUSH/POP/CALL/RET per handshake, owns the stack pointer, splits each
//  32-bit access into four little-endian byte beats and returns loaded/popped words
//  to write-back.
// PARAMETERS
//  ADDR_W      10    byte-address width of data memory (1024 bytes)
//  SP_INIT     1024  SP reset value (empty stack); SP register is ADDR_W+1 bits
//  STACK_BASE  768   lowest legal stack byte; SP==STACK_BASE means full (64 words)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       execute presents an op
//  in_ready     out  1       controller can accept (IDLE only)
//  opcode       in   6       LW 000101, LW.POI 000110, SW 000111, CALL 001101,
//                            RET 001110, PUSH 001111, POP 010000
//  alu_addr     in   32      effective byte address for LW/LW.POI/SW; [31:ADDR_W] ignored
//  store_data   in   32      Rd for SW/PUSH
//  pc           in   32      word-indexed PC (CALL)
//  rs1          in   32      base register (LW.POI post-increment)
//  mem_addr     out  ADDR_W  byte address
//  mem_re       out  1       byte read strobe; mem_rdata valid the following cycle
//  mem_we       out  1       byte write strobe
//  mem_wdata    out  8       byte to write
//  mem_rdata    in   8       byte read data
//  wb_valid     out  1       one-cycle completion pulse
//  wb_data      out  32      loaded/popped word (LW, LW.POI, POP, RET); else 0
//  wb_is_ret    out  1       wb_data is a return PC
//  wb_rs1_we    out  1       LW.POI: write wb_rs1 back to Rs1
//  wb_rs1       out  32      rs1 + 1
//  err_ovf      out  1       PUSH/CALL while full (with wb_valid)
//  err_unf      out  1       POP/RET while empty (with wb_valid)
//  sp_out       out  ADDR_W+1  current SP
// BEHAVIOUR
//  Reset: state IDLE, SP=SP_INIT, all other outputs 0; in_ready=1 after reset.
//  Accept on edge with in_valid&&in_ready; op fields latched. Non-memory opcodes are
//   accepted and dropped (no strobes, no wb_valid).
//  FSM: IDLE -> ACCESS (beat 0..3, 2-bit counter) -> [DRAIN for reads] -> DONE -> IDLE.
//  Base address: LW/SW -> alu_addr[ADDR_W-1:0]; PUSH/CALL -> SP-4 (SP updated at accept);
//   POP/RET -> SP (SP+=4 at accept). Beat k drives base+k, wrapping modulo 2^ADDR_W.
//  Writes: byte k = data[8k+7:8k]; CALL writes pc+1. Beats on cycles 1-4 after accept;
//   wb_valid on cycle 5.
//  Reads: mem_re beats cycles 1-4; byte k captured cycle k+2 into wb_data[8k+7:8k];
//   DRAIN captures byte 3; wb_valid on cycle 6.
//  Full: PUSH/CALL with SP==STACK_BASE -> no strobes, SP unchanged, ACCESS skipped,
//   wb_valid+err_ovf on cycle 1. Empty: POP/RET with SP==SP_INIT -> same with err_unf,
//   wb_data=0.
//  Only one op in flight; in_ready=0 outside IDLE, so no accept overlaps an access.
//  Reset mid-op: immediate return to IDLE, SP=SP_INIT; bytes already written remain.
//  mem_re/mem_we are never both high; both 0 outside ACCESS.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: LW/LW.POI/SW with alu_addr[1:0]!=0 -> no strobes, wb_valid
//   on cycle 1 with extra output err_misalign=1 (port exists only when defined).
//  Undefined: unaligned addresses are used as-is, beats wrap; no err_misalign port.
// STRUCTURE
//  Package mem_stage_pkg: opcode localparams, FSM state enum, beat-count constant 4.
//  Sub-module stack_ptr_reg: SP register, full/empty compare, +/-4 update, async reset.
// TESTING
//  1 Reset, then SW addr=0x10 data=0xA1B2C3D4 -> bytes 0x10..0x13 = D4,C3,B2,A1; wb_valid cycle 5.
//  2 LW addr=0x10 after test 1 -> wb_data=0xA1B2C3D4 on cycle 6; LW.POI rs1=7 -> wb_rs1=8, wb_rs1_we=1.
//  3 PUSH 0x11223344 then POP -> SP 1024->1020->1024; wb_data=0x11223344.
//  4 CALL pc=0x40 then RET -> bytes 1020..1023 = 41,00,00,00; wb_data=0x41, wb_is_ret=1.
//  5 POP at reset SP -> err_unf=1, no strobes; 64 PUSHes then PUSH -> err_ovf=1, SP=768.
//  6 rst_n low mid-SW (after beat 1) -> IDLE, SP=1024, outputs 0; with ALIGN_CHECK_EN,
//    LW addr=0x11 -> err_misalign=1, no mem_re.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state encoding and beat constants for the memory-stage sequencer.
package mem_stage_pkg;

    localparam logic [5:0] OP_LW     = 6'b000101;
    localparam logic [5:0] OP_LW_POI = 6'b000110;
    localparam logic [5:0] OP_SW     = 6'b000111;
    localparam logic [5:0] OP_CALL   = 6'b001101;
    localparam logic [5:0] OP_RET    = 6'b001110;
    localparam logic [5:0] OP_PUSH   = 6'b001111;
    localparam logic [5:0] OP_POP    = 6'b010000;

    localparam int BEATS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        DONE
    } state_t;

    // Little-endian byte lane k of a 32-bit word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/stack_ptr_reg.sv
// Stack pointer register: grows downward one word at a time, with full/empty flags.
module stack_ptr_reg
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int SP_INIT    = 1024,
    parameter int STACK_BASE = 768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec,
    input  logic              inc,
    output logic [ADDR_W:0]   sp,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] SP_RST = (ADDR_W + 1)'(SP_INIT);
    localparam logic [ADDR_W:0] SP_MIN = (ADDR_W + 1)'(STACK_BASE);
    localparam logic [ADDR_W:0] STEP   = (ADDR_W + 1)'(BEATS);

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= SP_RST;
        end else if (dec) begin
            sp <= sp - STEP;
        end else if (inc) begin
            sp <= sp + STEP;
        end
    end

    assign full  = (sp == SP_MIN);
    assign empty = (sp == SP_RST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: splits word accesses into four byte beats and owns the SP.
// Optional ALIGN_CHECK_EN rejects unaligned LW/LW.POI/SW and adds the err_misalign port.
module mem_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int SP_INIT    = 1024,
    parameter int STACK_BASE = 768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       pc,
    input  logic [31:0]       rs1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              wb_is_ret,
    output logic              wb_rs1_we,
    output logic [31:0]       wb_rs1,
    output logic              err_ovf,
    output logic              err_unf,
    output logic [ADDR_W:0]   sp_out
`ifdef ALIGN_CHECK_EN
    ,
    output logic              err_misalign
`endif
);

    localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(BEATS);

    state_t            state;
    logic [1:0]        beat;
    logic [1:0]        beat_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [23:0]       word_q;
    logic              is_read_q, is_poi_q, is_ret_q;
    logic [31:0]       rs1_q;

    logic              is_lw, is_sw, is_push, is_pop, is_rd, is_wr;
    logic              full, empty, ovf, unf, misalign, fault, sp_dec, sp_inc;
    logic [ADDR_W:0]   sp, sp_m4;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic              unused_bits;

    assign is_lw   = (opcode == OP_LW) || (opcode == OP_LW_POI);
    assign is_sw   = (opcode == OP_SW);
    assign is_push = (opcode == OP_PUSH) || (opcode == OP_CALL);
    assign is_pop  = (opcode == OP_POP) || (opcode == OP_RET);
    assign is_rd   = is_lw || is_pop;
    assign is_wr   = is_sw || is_push;

`ifdef ALIGN_CHECK_EN
    assign misalign = (is_lw || is_sw) && (alu_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign ovf    = is_push && full;
    assign unf    = is_pop && empty;
    assign fault  = ovf || unf || misalign;
    assign sp_dec = in_valid && in_ready && is_push && !full;
    assign sp_inc = in_valid && in_ready && is_pop && !empty;

    // Stack ops address the pre-update SP: PUSH/CALL fill the word below it, POP/RET read at it.
    assign sp_m4 = sp - STEP;
    assign base  = is_push ? sp_m4[ADDR_W-1:0] :
                   is_pop  ? sp[ADDR_W-1:0]    : alu_addr[ADDR_W-1:0];
    assign wdata = (opcode == OP_CALL) ? pc + 32'd1 : store_data;

    assign beat_nxt    = beat + 2'd1;
    assign in_ready    = (state == IDLE);
    assign sp_out      = sp;
    assign unused_bits = ^{alu_addr[31:ADDR_W], sp_m4[ADDR_W]};

    stack_ptr_reg #(
        .ADDR_W     (ADDR_W),
        .SP_INIT    (SP_INIT),
        .STACK_BASE (STACK_BASE)
    ) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (sp_dec),
        .inc   (sp_inc),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= 2'd0;
            base_q    <= '0;
            wdata_q   <= '0;
            word_q    <= '0;
            is_read_q <= 1'b0;
            is_poi_q  <= 1'b0;
            is_ret_q  <= 1'b0;
            rs1_q     <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_is_ret <= 1'b0;
            wb_rs1_we <= 1'b0;
            wb_rs1    <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
`ifdef ALIGN_CHECK_EN
            err_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    base_q    <= base;
                    wdata_q   <= wdata;
                    is_read_q <= is_rd;
                    is_poi_q  <= (opcode == OP_LW_POI);
                    is_ret_q  <= (opcode == OP_RET);
                    rs1_q     <= rs1 + 32'd1;
                    if (fault) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        err_ovf  <= ovf;
                        err_unf  <= unf;
`ifdef ALIGN_CHECK_EN
                        err_misalign <= misalign;
`endif
                    end else if (is_rd || is_wr) begin
                        state     <= ACCESS;
                        beat      <= 2'd0;
                        mem_addr  <= base;
                        mem_re    <= is_rd;
                        mem_we    <= is_wr;
                        mem_wdata <= is_wr ? wdata[7:0] : 8'h00;
                    end
                end
                ACCESS: begin
                    // Read data lags its strobe by one cycle, so beat k lands byte k-1.
                    if (is_read_q) begin
                        case (beat)
                            2'd1:    word_q[7:0]   <= mem_rdata;
                            2'd2:    word_q[15:8]  <= mem_rdata;
                            2'd3:    word_q[23:16] <= mem_rdata;
                            default: ;
                        endcase
                    end
                    if (beat == 2'd3) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (is_read_q) begin
                            state <= DRAIN;
                        end else begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                        end
                    end else begin
                        beat     <= beat_nxt;
                        mem_addr <= base_q + ADDR_W'(beat_nxt);
                        if (mem_we) mem_wdata <= get_byte(wdata_q, beat_nxt);
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    wb_valid  <= 1'b1;
                    wb_data   <= {mem_rdata, word_q};
                    wb_is_ret <= is_ret_q;
                    wb_rs1_we <= is_poi_q;
                    wb_rs1    <= is_poi_q ? rs1_q : 32'd0;
                end
                DONE: begin
                    state     <= IDLE;
                    wb_valid  <= 1'b0;
                    wb_data   <= '0;
                    wb_is_ret <= 1'b0;
                    wb_rs1_we <= 1'b0;
                    wb_rs1    <= '0;
                    err_ovf   <= 1'b0;
                    err_unf   <= 1'b0;
`ifdef ALIGN_CHECK_EN
                    err_misalign <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-wide memory model (one-cycle read latency).
module tb_mem_access_ctrl;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [31:0] alu_addr = '0, store_data = '0, pc = '0, rs1 = '0;
    logic [9:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        wb_valid, wb_is_ret, wb_rs1_we, err_ovf, err_unf;
    logic [31:0] wb_data, wb_rs1;
    logic [10:0] sp_out;
`ifdef ALIGN_CHECK_EN
    logic        err_misalign;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .alu_addr   (alu_addr),
        .store_data (store_data),
        .pc         (pc),
        .rs1        (rs1),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_is_ret  (wb_is_ret),
        .wb_rs1_we  (wb_rs1_we),
        .wb_rs1     (wb_rs1),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf),
        .sp_out     (sp_out)
`ifdef ALIGN_CHECK_EN
        ,
        .err_misalign (err_misalign)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        is_ret;
        logic        rs1_we;
        logic [31:0] rs1;
        logic        ovf;
        logic        unf;
        logic        mis;
        int          lat;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [0:1023];
    int         cyc = 0;
    int         strobes = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic exp_t mk(logic [31:0] d, logic ret, logic rwe, logic [31:0] r,
                                logic o, logic u, logic m, int lat);
        exp_t e;
        e.data = d; e.is_ret = ret; e.rs1_we = rwe; e.rs1 = r;
        e.ovf = o; e.unf = u; e.mis = m; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Memory model: writes land at the edge, read data appears the cycle after the strobe.
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    initial begin : monitor
        exp_t e;
        int   lat;
        logic mis_obs;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_checks++;
                if (mem_re && mem_we) begin
                    n_fail++;
                    $display("FAIL strobe_exclusive: mem_re=%b mem_we=%b, required not both high", mem_re, mem_we);
                end
                if (mem_re || mem_we) strobes++;
                if (wb_valid) begin
`ifdef ALIGN_CHECK_EN
                    mis_obs = err_misalign;
`else
                    mis_obs = 1'b0;
`endif
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL wb_unexpected: wb_valid=1 data=%h, required no completion", wb_data);
                    end else begin
                        e   = sb.pop_front();
                        lat = cyc - e.acc + 1;
                        if (wb_data !== e.data || wb_is_ret !== e.is_ret || wb_rs1_we !== e.rs1_we ||
                            (e.rs1_we && wb_rs1 !== e.rs1) || err_ovf !== e.ovf || err_unf !== e.unf ||
                            mis_obs !== e.mis || lat != e.lat) begin
                            n_fail++;
                            $display("FAIL wb_result: got data=%h ret=%b rwe=%b rs1=%h ovf=%b unf=%b mis=%b cycle=%0d, required data=%h ret=%b rwe=%b rs1=%h ovf=%b unf=%b mis=%b cycle=%0d",
                                     wb_data, wb_is_ret, wb_rs1_we, wb_rs1, err_ovf, err_unf, mis_obs, lat,
                                     e.data, e.is_ret, e.rs1_we, e.rs1, e.ovf, e.unf, e.mis, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] pcv, input logic [31:0] rs1v, input bit exp_wb, input exp_t e);
        @(negedge clk);
        opcode = op; alu_addr = addr; store_data = data; pc = pcv; rs1 = rs1v;
        in_valid = 1'b1;
        e.acc = cyc + 1;
        if (exp_wb) sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready && sb.size() == 0) && n < 40);
        n_checks++;
        if (!(in_ready && sb.size() == 0)) begin
            n_fail++;
            $display("FAIL %s_timeout: in_ready=%b pending=%0d, required idle with none pending", tag, in_ready, sb.size());
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] pcv, input logic [31:0] rs1v, input exp_t e);
        send(op, addr, data, pcv, rs1v, 1'b1, e);
        wait_idle(tag);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, mem_re, mem_we, wb_valid, err_ovf, err_unf, wb_rs1_we, wb_is_ret} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 10000000",
                     {in_ready, mem_re, mem_we, wb_valid, err_ovf, err_unf, wb_rs1_we, wb_is_ret});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, wb_data, wb_rs1} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h wb=%h rs1=%h, required all 0", mem_addr, mem_wdata, wb_data, wb_rs1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sp_out !== 11'd1024 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sp: got sp=%0d ready=%b, required sp=1024 ready=1", sp_out, in_ready);
        end
    endtask

    task automatic test_store_load();
        int s0 = strobes;
        run_op("sw", OP_SW, 32'h10, 32'hA1B2C3D4, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        n_checks++;
        if ({mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} !== 32'hA1B2C3D4) begin
            n_fail++;
            $display("FAIL sw_bytes: got %h, required a1b2c3d4", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]});
        end
        run_op("lw", OP_LW, 32'h10, 0, 0, 0, mk(32'hA1B2C3D4, 0, 0, 0, 0, 0, 0, 6));
        run_op("lw_poi", OP_LW_POI, 32'h10, 0, 0, 32'd7, mk(32'hA1B2C3D4, 0, 1, 32'd8, 0, 0, 0, 6));
        run_op("lw_hi", OP_LW, 32'hFFFF_FC10, 0, 0, 0, mk(32'hA1B2C3D4, 0, 0, 0, 0, 0, 0, 6));
        n_checks++;
        if (strobes - s0 != 16) begin
            n_fail++;
            $display("FAIL beat_count: got %0d strobes, required 16", strobes - s0);
        end
`ifndef ALIGN_CHECK_EN
        run_op("sw_wrap", OP_SW, 32'h3FE, 32'h55667788, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        n_checks++;
        if ({mem[16'h001], mem[16'h000], mem[16'h3FF], mem[16'h3FE]} !== 32'h55667788) begin
            n_fail++;
            $display("FAIL wrap_bytes: got %h, required 55667788", {mem[16'h001], mem[16'h000], mem[16'h3FF], mem[16'h3FE]});
        end
        run_op("lw_wrap", OP_LW, 32'h3FE, 0, 0, 0, mk(32'h55667788, 0, 0, 0, 0, 0, 0, 6));
`endif
    endtask

    task automatic test_stack();
        run_op("push", OP_PUSH, 0, 32'h11223344, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        n_checks++;
        if (sp_out !== 11'd1020 || {mem[1023], mem[1022], mem[1021], mem[1020]} !== 32'h11223344) begin
            n_fail++;
            $display("FAIL push_state: got sp=%0d word=%h, required sp=1020 word=11223344",
                     sp_out, {mem[1023], mem[1022], mem[1021], mem[1020]});
        end
        run_op("pop", OP_POP, 0, 0, 0, 0, mk(32'h11223344, 0, 0, 0, 0, 0, 0, 6));
        n_checks++;
        if (sp_out !== 11'd1024) begin
            n_fail++;
            $display("FAIL pop_sp: got %0d, required 1024", sp_out);
        end
    endtask

    task automatic test_call_ret();
        run_op("call", OP_CALL, 0, 32'hFFFF_FFFF, 32'h40, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        n_checks++;
        if (sp_out !== 11'd1020 || {mem[1023], mem[1022], mem[1021], mem[1020]} !== 32'h00000041) begin
            n_fail++;
            $display("FAIL call_state: got sp=%0d word=%h, required sp=1020 word=00000041",
                     sp_out, {mem[1023], mem[1022], mem[1021], mem[1020]});
        end
        run_op("ret", OP_RET, 0, 0, 0, 0, mk(32'h41, 1, 0, 0, 0, 0, 0, 6));
        n_checks++;
        if (sp_out !== 11'd1024) begin
            n_fail++;
            $display("FAIL ret_sp: got %0d, required 1024", sp_out);
        end
    endtask

    task automatic test_stack_limits();
        int s0 = strobes;
        run_op("pop_empty", OP_POP, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 1));
        run_op("ret_empty", OP_RET, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 1));
        n_checks++;
        if (strobes != s0 || sp_out !== 11'd1024) begin
            n_fail++;
            $display("FAIL underflow_side: got strobes=%0d sp=%0d, required strobes=0 sp=1024", strobes - s0, sp_out);
        end
        for (int i = 0; i < 64; i++)
            run_op("fill", OP_PUSH, 0, 32'hC0DE_0000 + i, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        n_checks++;
        if (sp_out !== 11'd768) begin
            n_fail++;
            $display("FAIL full_sp: got %0d, required 768", sp_out);
        end
        s0 = strobes;
        run_op("push_full", OP_PUSH, 0, 32'h12345678, 0, 0, mk(0, 0, 0, 0, 1, 0, 0, 1));
        run_op("call_full", OP_CALL, 0, 0, 32'h99, 0, mk(0, 0, 0, 0, 1, 0, 0, 1));
        n_checks++;
        if (strobes != s0 || sp_out !== 11'd768) begin
            n_fail++;
            $display("FAIL overflow_side: got strobes=%0d sp=%0d, required strobes=0 sp=768", strobes - s0, sp_out);
        end
        run_op("pop_top", OP_POP, 0, 0, 0, 0, mk(32'hC0DE_003F, 0, 0, 0, 0, 0, 0, 6));
        n_checks++;
        if (sp_out !== 11'd772) begin
            n_fail++;
            $display("FAIL pop_top_sp: got %0d, required 772", sp_out);
        end
    endtask

    task automatic test_dropped_op();
        int         s0 = strobes;
        logic [10:0] sp0 = sp_out;
        send(6'b000000, 32'h10, 32'hFFFF_FFFF, 0, 0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (8) @(negedge clk);
        n_checks++;
        if (strobes != s0 || sp_out !== sp0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped_op: got strobes=%0d sp=%0d ready=%b, required strobes=0 sp=%0d ready=1",
                     strobes - s0, sp_out, in_ready, sp0);
        end
    endtask

    task automatic test_reset_mid_op();
        run_op("prefill", OP_SW, 32'h20, 32'h11111111, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 5));
        send(OP_SW, 32'h20, 32'hDEADBEEF, 0, 0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 5));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if ({in_ready, mem_re, mem_we, wb_valid, mem_addr, mem_wdata} !== {1'b1, 21'd0} || sp_out !== 11'd1024) begin
            n_fail++;
            $display("FAIL midop_reset: got ready=%b re=%b we=%b wbv=%b addr=%h wdata=%h sp=%0d, required ready=1 others 0 sp=1024",
                     in_ready, mem_re, mem_we, wb_valid, mem_addr, mem_wdata, sp_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]} !== 32'h1111BEEF) begin
            n_fail++;
            $display("FAIL midop_bytes: got %h, required 1111beef", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]});
        end
        run_op("lw_after_rst", OP_LW, 32'h20, 0, 0, 0, mk(32'h1111BEEF, 0, 0, 0, 0, 0, 0, 6));
    endtask

`ifdef ALIGN_CHECK_EN
    task automatic test_misalign();
        int s0 = strobes;
        run_op("lw_mis", OP_LW, 32'h11, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        run_op("sw_mis", OP_SW, 32'h12, 32'hFFFF_FFFF, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        n_checks++;
        if (strobes != s0) begin
            n_fail++;
            $display("FAIL misalign_strobes: got %0d, required 0", strobes - s0);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_stack();
        test_call_ret();
        test_stack_limits();
        test_dropped_op();
        test_reset_mid_op();
`ifdef ALIGN_CHECK_EN
        test_misalign();
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
